// File: rtl/serial_pkg.sv
// Shared types and default sizing for the serial word controller.
package serial_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOADED = 2'd1,
      ST_SHIFT  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int DEF_WIDTH     = 16;
   localparam int DEF_BIT_TICKS = 10;

endpackage

// File: rtl/btn_edge.sv
// Raw button conditioning: two-flop synchronizer followed by a rising-edge
// detector. A held button yields a single one-cycle pulse.
module btn_edge (
   input  logic clk,
   input  logic nRST,
   input  logic btn,
   output logic pulse
);

   logic sync0;
   logic sync1;
   logic prev;

   // synchronize the raw level, then keep one delayed copy for edge detection
   always_ff @(posedge clk) begin
      if (nRST) begin
         sync0 <= 1'b0;
         sync1 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync0 <= btn;
         sync1 <= sync0;
         prev  <= sync1;
      end
   end

   assign pulse = sync1 & ~prev;

endmodule

// File: rtl/serial_ctrl.sv
// Button-driven serial word transfer: load a parallel word, then shift it out
// MSB first while assembling a receive word from serial_in.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | nothing loaded; only a load press is honoured
//   ST_LOADED | tx word captured; load recaptures, start begins transfer
//   ST_SHIFT  | transfer running, one bit per BIT_TICKS clocks
//   ST_DONE   | transfer complete, rx_word valid; load moves to LOADED
module serial_ctrl
   import serial_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int BIT_TICKS = DEF_BIT_TICKS
) (
   input  logic                     clk,
   input  logic                     nRST,
   input  logic                     load_btn,
   input  logic                     start_btn,
   input  logic [WIDTH-1:0]         pb_in,
   input  logic                     serial_in,
   output logic                     serial_out,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(WIDTH):0]   bit_cnt,
   output logic [WIDTH-1:0]         tx_word,
   output logic [WIDTH-1:0]         rx_word
);

   localparam int CW = $clog2(WIDTH) + 1;

   state_t            state;
   state_t            state_nxt;
   logic              load_pulse;
   logic              start_pulse;
   logic [7:0]        tick_cnt;
   logic [WIDTH-1:0]  tx_sr;
   // The newest received bit goes straight into rx_word on the final edge,
   // so only WIDTH-1 earlier bits need to be held here.
   logic [WIDTH-2:0]  rx_sr;
   logic              tick_end;
   logic              last_bit;
   logic              ld_word;
   logic              clr_xfer;
   logic              bit_end;

   btn_edge u_load_edge (
      .clk   (clk),
      .nRST  (nRST),
      .btn   (load_btn),
      .pulse (load_pulse)
   );

   btn_edge u_start_edge (
      .clk   (clk),
      .nRST  (nRST),
      .btn   (start_btn),
      .pulse (start_pulse)
   );

   assign tick_end = (tick_cnt == 8'(BIT_TICKS - 1));
   assign last_bit = (bit_cnt == CW'(WIDTH - 1));

   // state register
   always_ff @(posedge clk) begin
      if (nRST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state and datapath strobes; load has priority over start in LOADED
   always_comb begin
      state_nxt = state;
      ld_word   = 1'b0;
      clr_xfer  = 1'b0;
      bit_end   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (load_pulse) begin
               ld_word   = 1'b1;
               state_nxt = ST_LOADED;
            end
         end
         ST_LOADED: begin
            if (load_pulse) begin
               ld_word = 1'b1;
            end else if (start_pulse) begin
               clr_xfer  = 1'b1;
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (tick_end) begin
               bit_end = 1'b1;
               if (last_bit) begin
                  state_nxt = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (load_pulse) begin
               ld_word   = 1'b1;
               state_nxt = ST_LOADED;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // word capture, bit timing and shift registers
   always_ff @(posedge clk) begin
      if (nRST) begin
         tx_word  <= '0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         rx_word  <= '0;
         bit_cnt  <= '0;
         tick_cnt <= '0;
      end else begin
         if (ld_word) begin
            tx_word <= pb_in;
            tx_sr   <= pb_in;
         end
         if (clr_xfer) begin
            bit_cnt  <= '0;
            tick_cnt <= '0;
            rx_sr    <= '0;
         end else if (state == ST_SHIFT) begin
            if (bit_end) begin
               rx_sr    <= {rx_sr[WIDTH-3:0], serial_in};
               tx_sr    <= {tx_sr[WIDTH-2:0], 1'b0};
               bit_cnt  <= bit_cnt + CW'(1);
               tick_cnt <= '0;
            end else begin
               tick_cnt <= tick_cnt + 8'd1;
            end
         end
         if (bit_end && last_bit) begin
            rx_word <= {rx_sr, serial_in};
         end
      end
   end

   assign serial_out = (state == ST_SHIFT) ? tx_sr[WIDTH-1] : 1'b1;
   assign busy       = (state == ST_SHIFT);
   assign done       = (state == ST_DONE);

endmodule
